// File: rtl/axi_read_responder_pkg.sv
// Shared types for the AXI read responder: queued request record and responder FSM states.
package axi_read_responder_pkg;

    localparam int ADDR_WIDTH = 26;
    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 4;
    localparam int LEN_WIDTH  = 5;

    typedef struct packed {
        logic [ADDR_WIDTH-3:0] waddr;
        logic [LEN_WIDTH-1:0]  len;
        logic [ID_WIDTH-1:0]   id;
    } axi_rd_req_t;

    typedef enum logic [1:0] {
        RSP_IDLE  = 2'd0,
        RSP_WAIT  = 2'd1,
        RSP_BURST = 2'd2
    } rsp_state_t;

    // A zero beat count is served as a single beat.
    function automatic logic [LEN_WIDTH-1:0] norm_len(input logic [LEN_WIDTH-1:0] len);
        return (len == 5'd0) ? 5'd1 : len;
    endfunction

endpackage

// File: rtl/axi_read_responder_ram.sv
// Word-addressed synchronous RAM with registered read and a single write port.
module cache_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] q_r;

    // Storage write; contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read register only updates on an issued read so a stalled beat keeps its data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= '0;
        end else if (re) begin
            q_r <= mem_r[raddr];
        end
    end

    assign rdata = q_r;

endmodule

// File: rtl/axi_read_responder_req_fifo.sv
// Request queue for accepted AR transfers; head is visible combinationally while not empty.
module axi_req_fifo
    import axi_read_responder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  axi_rd_req_t               din,
    output axi_rd_req_t               head,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    axi_rd_req_t     mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_r + CW'(push) - CW'(pop);
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == CW'(0));
    assign count = count_r;

endmodule

// File: rtl/axi_read_responder.sv
// Memory-side AXI read slave: queues AR requests, inserts a fixed first-beat latency,
// then streams words from an internal RAM with full RREADY backpressure.
module axi_read_responder
    import axi_read_responder_pkg::*;
#(
    parameter int MEM_INDEX_WIDTH = 14,
    parameter int READ_LATENCY    = 4,
    parameter int REQ_DEPTH       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      araddr,
    input  logic [LEN_WIDTH-1:0]       arlen,
    input  logic [ID_WIDTH-1:0]        arid,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic [ID_WIDTH-1:0]        rid,
    output logic                       rlast,
    output logic                       rvalid,
    input  logic                       rready,
    input  logic                       bd_we,
    input  logic [MEM_INDEX_WIDTH-1:0] bd_addr,
    input  logic [DATA_WIDTH-1:0]      bd_wdata,
    output logic                       err_len0
);

    localparam int MIW = MEM_INDEX_WIDTH;
    localparam int CW  = $clog2(REQ_DEPTH) + 1;
    localparam logic [7:0] LAT_LOAD   = 8'(READ_LATENCY);
    localparam logic [7:0] LAT_RELOAD = (READ_LATENCY > 0) ? 8'(READ_LATENCY - 1) : 8'd0;

    rsp_state_t           state_r;
    logic [7:0]           lat_r;
    logic [MIW-1:0]       cur_addr_r;
    logic [LEN_WIDTH-1:0] beats_left_r;
    logic [ID_WIDTH-1:0]  cur_id_r;
    logic                 rvalid_r;
    logic                 rlast_r;
    logic [ID_WIDTH-1:0]  rid_r;
    logic                 arready_r;
    logic                 err_len0_r;

    axi_rd_req_t          req_in_s;
    axi_rd_req_t          head_s;
    logic                 q_full_s;
    logic                 q_empty_s;
    logic [CW-1:0]        q_count_s;
    logic [CW-1:0]        q_count_next_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 hs_s;
    logic                 ren_s;
    logic [MIW-1:0]       raddr_s;
    logic                 unused_s;

    assign push_s   = arvalid && arready_r;
    assign hs_s     = rvalid_r && rready;
    assign req_in_s = '{waddr: araddr[ADDR_WIDTH-1:2], len: norm_len(arlen), id: arid};
    assign unused_s = &{1'b0, araddr[1:0], head_s.waddr[ADDR_WIDTH-3:MIW], q_full_s};

    axi_req_fifo #(.DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (req_in_s),
        .head  (head_s),
        .full  (q_full_s),
        .empty (q_empty_s),
        .count (q_count_s)
    );

    cache_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(MIW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .re    (ren_s),
        .raddr (raddr_s),
        .rdata (rdata),
        .we    (bd_we),
        .waddr (bd_addr),
        .wdata (bd_wdata)
    );

    // Dequeue and RAM read issue decisions for the current cycle
    always_comb begin
        pop_s   = 1'b0;
        ren_s   = 1'b0;
        raddr_s = cur_addr_r;
        case (state_r)
            RSP_IDLE: begin
                pop_s = !q_empty_s;
            end
            RSP_WAIT: begin
                if (lat_r == 8'd0) begin
                    ren_s = 1'b1;
                end else begin
                    ren_s = 1'b0;
                end
            end
            RSP_BURST: begin
                if (hs_s && (beats_left_r > 5'd1)) begin
                    ren_s   = 1'b1;
                    raddr_s = cur_addr_r + MIW'(1);
                end else if (hs_s && !q_empty_s) begin
                    pop_s = 1'b1;
                    // Zero-latency builds read the next head now so bursts abut
                    if (READ_LATENCY == 0) begin
                        ren_s   = 1'b1;
                        raddr_s = head_s.waddr[MIW-1:0];
                    end else begin
                        ren_s = 1'b0;
                    end
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase
    end

    assign q_count_next_s = q_count_s + CW'(push_s) - CW'(pop_s);

    // Request acceptance, sticky zero-length flag and ARREADY from next occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arready_r  <= 1'b0;
            err_len0_r <= 1'b0;
        end else begin
            arready_r <= (q_count_next_s != CW'(REQ_DEPTH));
            if (push_s && (arlen == 5'd0)) begin
                err_len0_r <= 1'b1;
            end
        end
    end

    // Responder FSM with registered R-channel controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= RSP_IDLE;
            lat_r        <= 8'd0;
            cur_addr_r   <= '0;
            beats_left_r <= 5'd0;
            cur_id_r     <= 4'd0;
            rvalid_r     <= 1'b0;
            rlast_r      <= 1'b0;
            rid_r        <= 4'd0;
        end else begin
            case (state_r)
                RSP_IDLE: begin
                    if (!q_empty_s) begin
                        cur_addr_r   <= head_s.waddr[MIW-1:0];
                        beats_left_r <= head_s.len;
                        cur_id_r     <= head_s.id;
                        lat_r        <= LAT_LOAD;
                        state_r      <= RSP_WAIT;
                    end
                end
                RSP_WAIT: begin
                    if (lat_r == 8'd0) begin
                        state_r  <= RSP_BURST;
                        rvalid_r <= 1'b1;
                        rid_r    <= cur_id_r;
                        rlast_r  <= (beats_left_r == 5'd1);
                    end else begin
                        lat_r <= lat_r - 8'd1;
                    end
                end
                RSP_BURST: begin
                    if (hs_s) begin
                        if (beats_left_r > 5'd1) begin
                            cur_addr_r   <= cur_addr_r + MIW'(1);
                            beats_left_r <= beats_left_r - 5'd1;
                            rlast_r      <= (beats_left_r == 5'd2);
                        end else if (!q_empty_s) begin
                            cur_addr_r   <= head_s.waddr[MIW-1:0];
                            beats_left_r <= head_s.len;
                            cur_id_r     <= head_s.id;
                            if (READ_LATENCY == 0) begin
                                rid_r   <= head_s.id;
                                rlast_r <= (head_s.len == 5'd1);
                            end else begin
                                state_r  <= RSP_WAIT;
                                lat_r    <= LAT_RELOAD;
                                rvalid_r <= 1'b0;
                                rlast_r  <= 1'b0;
                            end
                        end else begin
                            state_r  <= RSP_IDLE;
                            rvalid_r <= 1'b0;
                            rlast_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r  <= RSP_IDLE;
                    rvalid_r <= 1'b0;
                    rlast_r  <= 1'b0;
                end
            endcase
        end
    end

    assign arready  = arready_r;
    assign rvalid   = rvalid_r;
    assign rlast    = rlast_r;
    assign rid      = rid_r;
    assign err_len0 = err_len0_r;

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench: latency-4 responder (dut_a) and latency-0 responder (dut_b) against a memory/burst scoreboard.
module tb_axi_read_responder;

    localparam int MEMW = 16384;

    typedef struct {
        int waddr;
        int len;
        int id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bd_we = 1'b0;
    logic [13:0] bd_addr = 14'd0;
    logic [31:0] bd_wdata = 32'd0;

    logic [25:0] a_araddr = 26'd0, b_araddr = 26'd0;
    logic [4:0]  a_arlen = 5'd0, b_arlen = 5'd0;
    logic [3:0]  a_arid = 4'd0, b_arid = 4'd0;
    logic        a_arvalid = 1'b0, b_arvalid = 1'b0;
    logic        a_rready = 1'b0, b_rready = 1'b0;
    logic        a_arready, b_arready, a_rvalid, b_rvalid, a_rlast, b_rlast, a_err, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic [3:0]  a_rid, b_rid;

    logic [31:0] mem_m [MEMW];
    exp_t        exp_q [$];
    int          fv_c [8];
    int          lh_c [8];
    int          hs_cnt;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    axi_read_responder #(.MEM_INDEX_WIDTH(14), .READ_LATENCY(4), .REQ_DEPTH(2)) dut_a (
        .clk(clk), .rst(rst), .araddr(a_araddr), .arlen(a_arlen), .arid(a_arid),
        .arvalid(a_arvalid), .arready(a_arready), .rdata(a_rdata), .rid(a_rid),
        .rlast(a_rlast), .rvalid(a_rvalid), .rready(a_rready), .bd_we(bd_we),
        .bd_addr(bd_addr), .bd_wdata(bd_wdata), .err_len0(a_err)
    );

    axi_read_responder #(.MEM_INDEX_WIDTH(14), .READ_LATENCY(0), .REQ_DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .araddr(b_araddr), .arlen(b_arlen), .arid(b_arid),
        .arvalid(b_arvalid), .arready(b_arready), .rdata(b_rdata), .rid(b_rid),
        .rlast(b_rlast), .rvalid(b_rvalid), .rready(b_rready), .bd_we(bd_we),
        .bd_addr(bd_addr), .bd_wdata(bd_wdata), .err_len0(b_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input int addr, input logic [31:0] data);
        bd_we    = 1'b1;
        bd_addr  = 14'(addr);
        bd_wdata = data;
        tick();
        bd_we = 1'b0;
        mem_m[addr] = data;
    endtask

    task automatic send_ar(input bit sel, input logic [25:0] addr, input logic [4:0] len, input logic [3:0] id);
        int   n;
        logic rdy;
        exp_t e;
        if (sel) begin b_araddr = addr; b_arlen = len; b_arid = id; b_arvalid = 1'b1; end
        else     begin a_araddr = addr; a_arlen = len; a_arid = id; a_arvalid = 1'b1; end
        n = 0;
        rdy = sel ? b_arready : a_arready;
        while (!rdy && n < 200) begin
            tick();
            n++;
            rdy = sel ? b_arready : a_arready;
        end
        check("ar_accept", 32'(rdy), 32'd1);
        tick();
        a_arvalid = 1'b0;
        b_arvalid = 1'b0;
        e.waddr = int'(addr >> 2) % MEMW;
        e.len   = (len == 5'd0) ? 1 : int'(len);
        e.id    = int'(id);
        exp_q.push_back(e);
    endtask

    // Accepts beats with the given RREADY pattern (indexed by valid cycles) and scores each valid cycle.
    task automatic drain(input bit sel, input logic [15:0] pat, input int max_cyc);
        int          beat, pidx, bidx, c;
        bit          seen;
        logic        rv, rl, rr;
        logic [31:0] rd;
        logic [3:0]  ri;
        beat = 0; pidx = 0; bidx = 0; seen = 1'b0; hs_cnt = 0;
        for (c = 0; c < max_cyc && exp_q.size() > 0; c++) begin
            rv = sel ? b_rvalid : a_rvalid;
            rl = sel ? b_rlast  : a_rlast;
            rd = sel ? b_rdata  : a_rdata;
            ri = sel ? b_rid    : a_rid;
            rr = 1'b0;
            if (rv) begin
                rr = pat[pidx % 16];
                pidx++;
                if (!seen) begin
                    fv_c[bidx] = c;
                    seen = 1'b1;
                end
                check("rdata", rd, mem_m[(exp_q[0].waddr + beat) % MEMW]);
                check("rid", 32'(ri), 32'(exp_q[0].id));
                check("rlast", 32'(rl), 32'(beat == exp_q[0].len - 1));
            end
            if (sel) b_rready = rr; else a_rready = rr;
            if (rv && rr) begin
                hs_cnt++;
                beat++;
                if (beat == exp_q[0].len) begin
                    lh_c[bidx] = c;
                    bidx++;
                    beat = 0;
                    seen = 1'b0;
                    void'(exp_q.pop_front());
                end
            end
            tick();
        end
        a_rready = 1'b0;
        b_rready = 1'b0;
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < MEMW; i++) mem_m[i] = 32'd0;

        // Reset state
        #1;
        check("rst_arready", 32'(a_arready), 32'd0);
        check("rst_rvalid", 32'(a_rvalid), 32'd0);
        check("rst_rlast", 32'(a_rlast), 32'd0);
        check("rst_rid", 32'(a_rid), 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("arready_after_rst", 32'(a_arready), 32'd1);

        for (int i = 'h100; i < 'h110; i++) bd_write(i, 32'(i));
        bd_write(16382, 32'hAAAA_3FFE);
        bd_write(16383, 32'hAAAA_3FFF);
        bd_write(0, 32'hC0DE_0000);
        bd_write(1, 32'hC0DE_0001);

        // 1: basic burst, first beat L+2 after AR
        send_ar(1'b0, 26'h400, 5'd4, 4'd3);
        drain(1'b0, 16'hFFFF, 100);
        check("t1_first_valid", 32'(fv_c[0]), 32'd6);
        check("t1_beats", 32'(hs_cnt), 32'd4);
        check("t1_idle_after", 32'(a_rvalid), 32'd0);

        // 2: backpressure pattern 1,0,0,1,0,1,1
        send_ar(1'b0, 26'h400, 5'd4, 4'd3);
        drain(1'b0, 16'hFF69, 100);
        check("t2_handshakes", 32'(hs_cnt), 32'd4);

        // 3: three back-to-back ARs with RREADY low
        send_ar(1'b0, 26'h404, 5'd2, 4'd1);
        send_ar(1'b0, 26'h414, 5'd2, 4'd2);
        send_ar(1'b0, 26'h424, 5'd3, 4'd3);
        check("t3_queue_full", 32'(a_arready), 32'd0);
        drain(1'b0, 16'hFFFF, 200);
        check("t3_gap12", 32'(fv_c[1] - lh_c[0]), 32'd5);
        check("t3_gap23", 32'(fv_c[2] - lh_c[1]), 32'd5);

        // 4: wrap at top of RAM, then zero-length request with aliased high address bits
        send_ar(1'b0, 26'h000FFF8, 5'd4, 4'd4);
        drain(1'b0, 16'hFFFF, 100);
        check("t4_err_before", 32'(a_err), 32'd0);
        send_ar(1'b0, 26'h2000404, 5'd0, 4'd9);
        drain(1'b0, 16'hFFFF, 100);
        check("t4_len0_beats", 32'(hs_cnt), 32'd1);
        check("t4_err_after", 32'(a_err), 32'd1);

        // 5: async reset during beat 2 of 4
        send_ar(1'b0, 26'h400, 5'd4, 4'd5);
        a_rready = 1'b1;
        n = 0;
        while (!a_rvalid && n < 50) begin
            tick();
            n++;
        end
        check("t5_first_valid", 32'(a_rvalid), 32'd1);
        tick();
        a_rready = 1'b0;
        check("t5_beat2_data", a_rdata, 32'h101);
        rst = 1'b1;
        #1;
        check("t5_rst_rvalid", 32'(a_rvalid), 32'd0);
        check("t5_rst_arready", 32'(a_arready), 32'd0);
        check("t5_rst_rdata", a_rdata, 32'd0);
        check("t5_rst_err", 32'(a_err), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        send_ar(1'b0, 26'h420, 5'd2, 4'd6);
        drain(1'b0, 16'hFFFF, 100);
        check("t5_new_first_valid", 32'(fv_c[0]), 32'd6);
        check("t5_new_beats", 32'(hs_cnt), 32'd2);

        // 6: zero-latency build
        send_ar(1'b1, 26'h400, 5'd4, 4'd7);
        drain(1'b1, 16'hFFFF, 100);
        check("t6_first_valid", 32'(fv_c[0]), 32'd2);
        send_ar(1'b1, 26'h420, 5'd2, 4'd8);
        send_ar(1'b1, 26'h430, 5'd3, 4'd9);
        drain(1'b1, 16'hFFFF, 100);
        check("t6_no_bubble", 32'(fv_c[1] - lh_c[0]), 32'd1);
        check("t6_beats", 32'(hs_cnt), 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
